// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions: flag instruction encoding, P bit positions,
// ALU flag update mask bits and the stored-flag record.
package cpu_pkg;

    localparam int unsigned FLAG_OP_W = 3;
    localparam int unsigned P_W       = 8;
    localparam int unsigned UPD_W     = 4;

    typedef enum logic [FLAG_OP_W-1:0] {
        FOP_NONE,
        FOP_CLC,
        FOP_SEC,
        FOP_CLI,
        FOP_SEI,
        FOP_CLV,
        FOP_CLD,
        FOP_SED
    } flag_op_t;

    localparam int unsigned P_C = 0;
    localparam int unsigned P_Z = 1;
    localparam int unsigned P_I = 2;
    localparam int unsigned P_D = 3;
    localparam int unsigned P_B = 4;
    localparam int unsigned P_U = 5;
    localparam int unsigned P_V = 6;
    localparam int unsigned P_N = 7;

    // upd_mask bit order is {N,V,Z,C}
    localparam int unsigned UPD_C = 0;
    localparam int unsigned UPD_Z = 1;
    localparam int unsigned UPD_V = 2;
    localparam int unsigned UPD_N = 3;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    // Assemble a P byte; bit 5 always reads 1, bit 4 comes from the caller.
    function automatic logic [P_W-1:0] pack_p(input flags_t f, input logic b);
        logic [P_W-1:0] r;
        r      = '0;
        r[P_N] = f.n;
        r[P_V] = f.v;
        r[P_U] = 1'b1;
        r[P_B] = b;
        r[P_D] = f.d;
        r[P_I] = f.i;
        r[P_Z] = f.z;
        r[P_C] = f.c;
        return r;
    endfunction

endpackage

// File: rtl/status_reg_if.sv
// Status register connection bundle: ALU flags, flag ops, stack byte,
// interrupt lines in; P views and interrupt status out.
interface status_reg_if;
    import cpu_pkg::*;

    logic                 alu_n;
    logic                 alu_v;
    logic                 alu_z;
    logic                 alu_c;
    logic [UPD_W-1:0]     upd_mask;
    flag_op_t             flag_op;
    logic [P_W-1:0]       db_in;
    logic                 db_load;
    logic                 push_b;
    logic                 sync;
    logic                 irq_n;
    logic                 nmi_n;
    logic                 intr_ack;
    logic                 ack_nmi;

    logic [P_W-1:0]       p;
    logic [P_W-1:0]       p_push;
    logic                 c_flag;
    logic                 d_flag;
    logic                 int_req;
    logic                 nmi_pend;

    modport master (
        output alu_n, alu_v, alu_z, alu_c, upd_mask, flag_op, db_in, db_load,
               push_b, sync, irq_n, nmi_n, intr_ack, ack_nmi,
        input  p, p_push, c_flag, d_flag, int_req, nmi_pend
    );

    modport slave (
        input  alu_n, alu_v, alu_z, alu_c, upd_mask, flag_op, db_in, db_load,
               push_b, sync, irq_n, nmi_n, intr_ack, ack_nmi,
        output p, p_push, c_flag, d_flag, int_req, nmi_pend
    );

endinterface

// File: rtl/status_reg_int_detect.sv
// NMI falling-edge latch plus sync-delayed I mask, combined into int_req
// so that CLI/SEI/PLP take effect on masking one instruction late.
module int_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flag_i,
    input  logic sync_i,
    input  logic irq_n_i,
    input  logic nmi_n_i,
    input  logic intr_ack_i,
    input  logic ack_nmi_i,
    output logic int_req_o,
    output logic nmi_pend_o
);

    logic nmi_prev_q, nmi_prev_d;
    logic nmi_pend_q, nmi_pend_d;
    logic i_mask_q,   i_mask_d;

    // A new edge outranks an acknowledge landing in the same cycle.
    always_comb begin
        nmi_prev_d = nmi_n_i;
        nmi_pend_d = nmi_pend_q;
        i_mask_d   = i_mask_q;
        if (intr_ack_i && ack_nmi_i) begin
            nmi_pend_d = 1'b0;
        end
        if (nmi_prev_q && !nmi_n_i) begin
            nmi_pend_d = 1'b1;
        end
        if (sync_i) begin
            i_mask_d = i_flag_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            i_mask_q   <= 1'b1;
        end else begin
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            i_mask_q   <= i_mask_d;
        end
    end

    assign int_req_o  = nmi_pend_q | (~irq_n_i & ~i_mask_q);
    assign nmi_pend_o = nmi_pend_q;

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register P with flag ops, stack load/push and interrupt gating.
// Define CMOS_DCLR_EN to clear D on interrupt entry (65C02 behaviour).
module status_reg
    import cpu_pkg::*;
#(
    parameter bit RESET_D = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    status_reg_if.slave  bus
);

`ifdef CMOS_DCLR_EN
    localparam bit DCLR_ON = 1'b1;
`else
    localparam bit DCLR_ON = 1'b0;
`endif

    localparam flags_t FLAGS_RST = '{n: 1'b0, v: 1'b0, d: RESET_D,
                                     i: 1'b1, z: 1'b0, c: 1'b0};

    flags_t flags_q, flags_d;
    logic   unused_db_bits;

    // Sources applied lowest priority first so later writes win per bit.
    always_comb begin
        flags_d = flags_q;
        if (bus.upd_mask[UPD_N]) flags_d.n = bus.alu_n;
        if (bus.upd_mask[UPD_V]) flags_d.v = bus.alu_v;
        if (bus.upd_mask[UPD_Z]) flags_d.z = bus.alu_z;
        if (bus.upd_mask[UPD_C]) flags_d.c = bus.alu_c;

        case (bus.flag_op)
            FOP_CLC: flags_d.c = 1'b0;
            FOP_SEC: flags_d.c = 1'b1;
            FOP_CLI: flags_d.i = 1'b0;
            FOP_SEI: flags_d.i = 1'b1;
            FOP_CLV: flags_d.v = 1'b0;
            FOP_CLD: flags_d.d = 1'b0;
            FOP_SED: flags_d.d = 1'b1;
            default: ;
        endcase

        if (bus.intr_ack) begin
            flags_d.i = 1'b1;
            if (DCLR_ON) flags_d.d = 1'b0;
        end

        if (bus.db_load) begin
            flags_d.n = bus.db_in[P_N];
            flags_d.v = bus.db_in[P_V];
            flags_d.d = bus.db_in[P_D];
            flags_d.i = bus.db_in[P_I];
            flags_d.z = bus.db_in[P_Z];
            flags_d.c = bus.db_in[P_C];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

    // B and unused bits of a pulled byte have no storage.
    assign unused_db_bits = ^{bus.db_in[P_B], bus.db_in[P_U]};

    assign bus.p      = pack_p(flags_q, 1'b1);
    assign bus.p_push = pack_p(flags_q, bus.push_b);
    assign bus.c_flag = flags_q.c;
    assign bus.d_flag = flags_q.d;

    int_detect u_int_detect (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flag_i   (flags_q.i),
        .sync_i     (bus.sync),
        .irq_n_i    (bus.irq_n),
        .nmi_n_i    (bus.nmi_n),
        .intr_ack_i (bus.intr_ack),
        .ack_nmi_i  (bus.ack_nmi),
        .int_req_o  (bus.int_req),
        .nmi_pend_o (bus.nmi_pend)
    );

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: vector table plus hand sequences for IRQ latency,
// NMI edges, interrupt entry and mid-sequence reset, checked via a scoreboard queue.
module tb_status_reg;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    status_reg_if bus ();

    status_reg #(.RESET_D(1'b0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] nvzc;
        logic [3:0] mask;
        logic [2:0] fop;
        logic [7:0] db_in;
        logic       db_load;
        logic       push_b;
        logic       sync;
        logic       irq;
        logic       nmi_low;
        logic       ack;
        logic       ack_nmi;
        logic [7:0] exp_p;
        logic [7:0] exp_push;
        logic       exp_int;
        logic       exp_nmi;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] p;
        logic [7:0] push;
        logic       int_req;
        logic       nmi_pend;
    } exp_t;

`ifdef CMOS_DCLR_EN
    localparam logic [7:0] ACK_P = 8'h34;
`else
    localparam logic [7:0] ACK_P = 8'h3C;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;
    vec_t tbl[13];
    vec_t h;

    function automatic vec_t tv(logic r, logic [3:0] nvzc, logic [3:0] mask, logic [2:0] fop,
                                logic [7:0] db, logic dl, logic pb,
                                logic [7:0] ep, logic [7:0] epush);
        vec_t v = '0;
        v.rst = r; v.nvzc = nvzc; v.mask = mask; v.fop = fop;
        v.db_in = db; v.db_load = dl; v.push_b = pb;
        v.exp_p = ep; v.exp_push = epush;
        return v;
    endfunction

    function automatic vec_t hs(logic [2:0] fop, logic sy, logic irq, logic nl, logic ak, logic an,
                                logic [7:0] ep, logic ei, logic en);
        vec_t v = '0;
        v.fop = fop; v.sync = sy; v.irq = irq; v.nmi_low = nl; v.ack = ak; v.ack_nmi = an;
        v.exp_p = ep; v.exp_push = ep & 8'hEF; v.exp_int = ei; v.exp_nmi = en;
        return v;
    endfunction

    task automatic check8(input string what, input int id, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %02h, expected %02h", what, id, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        rst          = v.rst;
        bus.alu_n    = v.nvzc[3];
        bus.alu_v    = v.nvzc[2];
        bus.alu_z    = v.nvzc[1];
        bus.alu_c    = v.nvzc[0];
        bus.upd_mask = v.mask;
        bus.flag_op  = flag_op_t'(v.fop);
        bus.db_in    = v.db_in;
        bus.db_load  = v.db_load;
        bus.push_b   = v.push_b;
        bus.sync     = v.sync;
        bus.irq_n    = ~v.irq;
        bus.nmi_n    = ~v.nmi_low;
        bus.intr_ack = v.ack;
        bus.ack_nmi  = v.ack_nmi;
        e.id = step_id; e.p = v.exp_p; e.push = v.exp_push;
        e.int_req = v.exp_int; e.nmi_pend = v.exp_nmi;
        sb.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check8("p",        e.id, bus.p,              e.p);
        check8("p_push",   e.id, bus.p_push,         e.push);
        check8("c_flag",   e.id, 8'(bus.c_flag),     8'(e.p[P_C]));
        check8("d_flag",   e.id, 8'(bus.d_flag),     8'(e.p[P_D]));
        check8("int_req",  e.id, 8'(bus.int_req),    8'(e.int_req));
        check8("nmi_pend", e.id, 8'(bus.nmi_pend),   8'(e.nmi_pend));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst nvzc     mask     fop       db     dl pb  p      push
        tbl[0]  = tv(1, 4'b0000, 4'b0000, FOP_NONE, 8'h00, 0, 0, 8'h34, 8'h24);
        tbl[1]  = tv(0, 4'b0000, 4'b0000, FOP_NONE, 8'h00, 0, 1, 8'h34, 8'h34);
        tbl[2]  = tv(0, 4'b1101, 4'b1011, FOP_NONE, 8'h00, 0, 0, 8'hB5, 8'hA5);
        tbl[3]  = tv(0, 4'b1101, 4'b1011, FOP_CLC,  8'h00, 0, 0, 8'hB4, 8'hA4);
        tbl[4]  = tv(0, 4'b0110, 4'b0100, FOP_SEC,  8'h00, 0, 0, 8'hF5, 8'hE5);
        tbl[5]  = tv(0, 4'b0000, 4'b0000, FOP_CLD,  8'hFF, 1, 0, 8'hFF, 8'hEF);
        tbl[6]  = tv(0, 4'b1111, 4'b1111, FOP_NONE, 8'h00, 1, 0, 8'h30, 8'h20);
        tbl[7]  = tv(0, 4'b0010, 4'b0010, FOP_NONE, 8'h00, 0, 0, 8'h32, 8'h22);
        tbl[8]  = tv(0, 4'b0100, 4'b0100, FOP_SED,  8'h00, 0, 0, 8'h7A, 8'h6A);
        tbl[9]  = tv(0, 4'b0001, 4'b0001, FOP_CLV,  8'h00, 0, 0, 8'h3B, 8'h2B);
        tbl[10] = tv(0, 4'b1000, 4'b1000, FOP_SEI,  8'h00, 0, 0, 8'hBF, 8'hAF);
        tbl[11] = tv(0, 4'b0000, 4'b0000, FOP_NONE, 8'h00, 0, 1, 8'hBF, 8'hBF);
        tbl[12] = tv(0, 4'b0000, 4'b1111, FOP_CLD,  8'h00, 0, 0, 8'h34, 8'h24);

        for (int i = 0; i < 13; i++) step(tbl[i]);

        // IRQ masking lags I by one sync
        step(hs(FOP_CLI,  1, 1, 0, 0, 0, 8'h30, 0, 0));
        step(hs(FOP_NONE, 0, 1, 0, 0, 0, 8'h30, 0, 0));
        step(hs(FOP_NONE, 1, 1, 0, 0, 0, 8'h30, 1, 0));
        step(hs(FOP_NONE, 0, 0, 0, 0, 0, 8'h30, 0, 0));
        step(hs(FOP_SEI,  0, 1, 0, 0, 0, 8'h34, 1, 0));
        step(hs(FOP_NONE, 1, 1, 0, 0, 0, 8'h34, 0, 0));

        // interrupt entry: I set beats CLI, D clear only on CMOS, db_load beats all
        step(hs(FOP_SED,  0, 0, 0, 0, 0, 8'h3C, 0, 0));
        step(hs(FOP_CLI,  0, 0, 0, 0, 0, 8'h38, 0, 0));
        step(hs(FOP_CLI,  0, 0, 0, 1, 0, ACK_P, 0, 0));
        h = hs(FOP_SEI, 0, 0, 0, 1, 0, 8'h30, 0, 0);
        h.db_load = 1'b1; h.db_in = 8'h00;
        step(h);
        step(hs(FOP_SEI,  0, 0, 0, 0, 0, 8'h34, 0, 0));

        // NMI edge, long low hold, acknowledge behaviour
        step(hs(FOP_NONE, 0, 0, 1, 0, 0, 8'h34, 1, 1));
        for (int i = 0; i < 10; i++) step(hs(FOP_NONE, 0, 0, 1, 0, 0, 8'h34, 1, 1));
        step(hs(FOP_NONE, 0, 0, 1, 1, 0, 8'h34, 1, 1));
        step(hs(FOP_NONE, 0, 0, 1, 1, 1, 8'h34, 0, 0));
        for (int i = 0; i < 8; i++) step(hs(FOP_NONE, 0, 0, 1, 0, 0, 8'h34, 0, 0));
        step(hs(FOP_NONE, 0, 0, 0, 0, 0, 8'h34, 0, 0));
        step(hs(FOP_NONE, 0, 0, 1, 1, 1, 8'h34, 1, 1));
        step(hs(FOP_NONE, 0, 0, 1, 1, 1, 8'h34, 0, 0));

        // reset in the middle of activity
        h = hs(FOP_NONE, 0, 0, 1, 0, 0, 8'hFF, 0, 0);
        h.db_load = 1'b1; h.db_in = 8'hFF;
        step(h);
        step(hs(FOP_NONE, 0, 0, 0, 0, 0, 8'hFF, 0, 0));
        step(hs(FOP_NONE, 0, 0, 1, 0, 0, 8'hFF, 1, 1));
        h = hs(FOP_SEC, 1, 1, 1, 1, 1, 8'h34, 0, 0);
        h.rst = 1'b1; h.db_load = 1'b1; h.db_in = 8'h00; h.nvzc = 4'b1111; h.mask = 4'b1111;
        step(h);
        step(hs(FOP_NONE, 0, 0, 1, 0, 0, 8'h34, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- Processor status register (P) for the 6502 core, directly downstream of the ALU.
- Captures the ALU's N/V/Z/C outputs under per-flag update masks and executes the flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED).
- Loads P from the data bus for PLP/RTI and forms the push byte for PHP/BRK/IRQ/NMI.
- Also owns NMI edge detection and IRQ masking with 6502-accurate I-flag latency. Feeds ci and D back to the ALU/decimal path and int_req to the sequencer.

Parameters:
- RESET_D, 0: value of the D flag after reset.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous active-high reset
- alu_n, alu_v, alu_z, alu_c  in  1 each  flag results from the ALU
- upd_mask  in  4  per-flag ALU update enable, bit order {N,V,Z,C}
- flag_op  in  3  flag instruction, flag_op_t encoding
- db_in  in  8  byte pulled from the stack (PLP/RTI)
- db_load  in  1  load P from db_in
- push_b  in  1  B bit value for p_push (1 = PHP/BRK, 0 = IRQ/NMI)
- sync  in  1  instruction boundary (opcode fetch cycle)
- irq_n  in  1  IRQ line, level, active low
- nmi_n  in  1  NMI line, falling-edge sensitive
- intr_ack  in  1  interrupt vector fetch cycle
- ack_nmi  in  1  qualifies intr_ack: 1 = NMI serviced
- p  out  8  live status {N,V,1,1,D,I,Z,C}
- p_push  out  8  push byte {N,V,1,push_b,D,I,Z,C}
- c_flag  out  1  C, drives ALU ci
- d_flag  out  1  D
- int_req  out  1  interrupt pending and unmasked
- nmi_pend  out  1  NMI latched, not yet acknowledged

Behaviour:
Storage and reset:
- Six stored flags: N, V, D, I, Z, C. Bits 5 and 4 are not stored. Bit 5 always reads 1; bit 4 reads 1 on p and push_b on p_push.
- Reset: N=V=Z=C=0, I=1, D=RESET_D, i_mask=1, nmi_pend=0, nmi_prev=1.
- All outputs are registered-flag derived. Flag updates become visible on p one cycle after the inputs are applied.

Per-cycle update priority, per bit, highest first:
1. db_load: all six flags take the corresponding db_in bits. db_in[5:4] are ignored.
2. flag_op, affecting only its target bit:
   - CLC/SEC write C
   - CLI/SEI write I
   - CLV writes V
   - CLD/SED write D
3. upd_mask[k]=1: flag takes the corresponding alu_* value.
- flag_op and upd_mask on different bits in the same cycle both take effect.
- db_load with any other source: db_load wins for all bits.

IRQ masking:
- i_mask is a copy of I that updates only on cycles where sync=1.
- int_req = nmi_pend | (~irq_n & ~i_mask), combinational from registers and irq_n.
- Effect: CLI/SEI/PLP change masking one instruction late, matching NMOS behaviour.

NMI detection:
- nmi_prev <= nmi_n every cycle.
- A falling edge (nmi_prev=1, nmi_n=0) sets nmi_pend.
- intr_ack & ack_nmi clears nmi_pend.
- Edge and clear in the same cycle: set wins.
- NMI held low does not re-trigger.

Interrupt entry:
- intr_ack sets I=1. This has lower priority than db_load and higher than flag_op.
- Reset mid-instruction: all state returns to reset values on the next edge regardless of other inputs.

Optional Feature:
- Macro CMOS_DCLR_EN.
- Defined: intr_ack also clears D (65C02 behaviour), with the same priority as the I set.
- Undefined: D is unchanged on interrupt entry.

Decomposition:
- Shared package cpu_pkg:
  - flag_op_t enum: FOP_NONE, FOP_CLC, FOP_SEC, FOP_CLI, FOP_SEI, FOP_CLV, FOP_CLD, FOP_SED
  - P bit index constants P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7
  - UPD_* mask bit constants
- Sub-module int_detect: NMI edge latch, i_mask register and int_req logic.

Test Plan:
- Reset -> p=8'h34 (RESET_D=0), int_req=0, nmi_pend=0; p_push with push_b=0 -> 8'h24.
- ALU N=1,V=1,Z=0,C=1, upd_mask=4'b1011 -> N=1, Z=0, C=1, V unchanged; same cycle flag_op=FOP_CLC -> C=0.
- db_load, db_in=8'hFF -> p=8'hFF next cycle; same cycle flag_op=FOP_CLD -> D=1 (db_load wins); db_in=8'h00 -> p=8'h30.
- irq_n=0, I=1, CLI executed, sync pulsed once -> int_req rises only after that sync, not in the CLI cycle.
- nmi_n 1->0, held low 20 cycles -> nmi_pend set once; intr_ack&ack_nmi clears it and stays clear; new edge coinciding with ack -> nmi_pend=1.
- D=1, intr_ack -> I=1, and D=0 only when CMOS_DCLR_EN is defined; reset asserted mid-sequence -> p=8'h34 next cycle.
